// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl
//   Initiator-side controller for the 16x8 dual-address lab RAM.  On start it
//   sweeps every read address in order and hands back each word with its
//   address tag.  Writes from the switch/key front-end are interleaved and win
//   over reads: a cycle with ram_we=1 issues no read.
//
// Ports
//   clk, clrn               system clock, async active-low reset
//   start                   begin a sweep (sampled in IDLE only)
//   wr_req/wr_addr/wr_data  write request, held until wr_ack
//   wr_ack                  one-cycle pulse, write issued
//   ram_we/ram_inaddr/ram_din   registered RAM write port
//   ram_outaddr/ram_dout    registered RAM read address, RAM read data
//   rd_valid/rd_addr/rd_data    returned word with its address tag
//   busy                    sweep in progress (SCAN or DRAIN)
//   done                    one-cycle pulse at sweep completion
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ram_outaddr parked at 0, waiting for start
//   ST_SCAN  | issuing one read per cycle whenever no write owns the RAM
//   ST_DRAIN | all reads issued, waiting for the tag pipe to empty
module ram_scan_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int WDATA_W   = 2,
  parameter int LAST_ADDR = 15
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               start,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WDATA_W-1:0] wr_data,
  output logic               wr_ack,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_inaddr,
  output logic [WDATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0]  ram_outaddr,
  input  logic [DATA_W-1:0]  ram_dout,
  output logic               rd_valid,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
  // Capture counter must reach LAST_ADDR+1, hence one extra bit.
  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  N_WORDS = CNT_W'(LAST_ADDR + 1);

  state_t              state_q, state_d;
  logic                wr_ack_q, wr_ack_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_inaddr_q, ram_inaddr_d;
  logic [WDATA_W-1:0]  ram_din_q, ram_din_d;
  logic [ADDR_W-1:0]   ram_outaddr_q, ram_outaddr_d;
  logic                s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic                s2_vld_q, s2_vld_d;
  logic [ADDR_W-1:0]   s2_addr_q, s2_addr_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [CNT_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic                done_q, done_d;
  logic                issue;

  always_comb begin
    state_d       = state_q;
    wr_ack_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_inaddr_d  = ram_inaddr_q;
    ram_din_d     = ram_din_q;
    ram_outaddr_d = ram_outaddr_q;
    rd_valid_d    = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_q;
    cap_cnt_d     = cap_cnt_q;
    done_d        = 1'b0;
    issue         = 1'b0;

    // wr_ack_q gating makes a held request alternate: one write per two cycles.
    if (wr_req && !wr_ack_q) begin
      ram_we_d     = 1'b1;
      wr_ack_d     = 1'b1;
      ram_inaddr_d = wr_addr;
      ram_din_d    = wr_data;
    end

    case (state_q)
      ST_IDLE: begin
        ram_outaddr_d = '0;
        cap_cnt_d     = '0;
        if (start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // The RAM ignores the read address while a write is in progress.
        if (!ram_we_q) begin
          issue = 1'b1;
          if (ram_outaddr_q == LAST) begin
            ram_outaddr_d = '0;
            state_d       = ST_DRAIN;
          end else begin
            ram_outaddr_d = ram_outaddr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!s1_vld_q && !s2_vld_q && (cap_cnt_q == N_WORDS)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Two tag stages cover the RAM's address latch plus its output register.
    s1_vld_d  = issue;
    s1_addr_d = ram_outaddr_q;
    s2_vld_d  = s1_vld_q;
    s2_addr_d = s1_addr_q;

    if (s2_vld_q) begin
      rd_valid_d = 1'b1;
      rd_addr_d  = s2_addr_q;
      rd_data_d  = ram_dout;
      cap_cnt_d  = cap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      wr_ack_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_inaddr_q  <= '0;
      ram_din_q     <= '0;
      ram_outaddr_q <= '0;
      s1_vld_q      <= 1'b0;
      s1_addr_q     <= '0;
      s2_vld_q      <= 1'b0;
      s2_addr_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
      cap_cnt_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ack_q      <= wr_ack_d;
      ram_we_q      <= ram_we_d;
      ram_inaddr_q  <= ram_inaddr_d;
      ram_din_q     <= ram_din_d;
      ram_outaddr_q <= ram_outaddr_d;
      s1_vld_q      <= s1_vld_d;
      s1_addr_q     <= s1_addr_d;
      s2_vld_q      <= s2_vld_d;
      s2_addr_q     <= s2_addr_d;
      rd_valid_q    <= rd_valid_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
      cap_cnt_q     <= cap_cnt_d;
      done_q        <= done_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign ram_we      = ram_we_q;
  assign ram_inaddr  = ram_inaddr_q;
  assign ram_din     = ram_din_q;
  assign ram_outaddr = ram_outaddr_q;
  assign rd_valid    = rd_valid_q;
  assign rd_addr     = rd_addr_q;
  assign rd_data     = rd_data_q;
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Testbench for ram_scan_ctrl: lab RAM model, behavioural reference model,
// per-cycle compare process, directed scenarios and a random traffic phase.
`timescale 1ns/1ps
module tb_ram_scan_ctrl;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       start = 1'b0;
  logic       wr_req = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [1:0] wr_data = 2'd0;
  logic       wr_ack, ram_we, rd_valid, busy, done;
  logic [3:0] ram_inaddr, ram_outaddr, rd_addr;
  logic [1:0] ram_din;
  logic [7:0] ram_dout, rd_data;

  always #5 clk = ~clk;

  ram_scan_ctrl dut (
    .clk(clk), .clrn(clrn), .start(start), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_we(ram_we), .ram_inaddr(ram_inaddr), .ram_din(ram_din),
    .ram_outaddr(ram_outaddr), .ram_dout(ram_dout), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
  );

  // ---------------- lab RAM ----------------
  logic       preload = 1'b0;
  logic [7:0] mem [16];
  logic [3:0] lat;
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h10 + i);
    else if (ram_we) mem[ram_inaddr][1:0] <= ram_din;
    if (!ram_we) lat <= ram_outaddr;
    ram_dout <= mem[lat];
  end

  // ---------------- counters / check ----------------
  int vec = 0;
  int err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Reads are tracked as a queue of in-flight words; a word's data is taken
  // from the shadow memory one cycle after it is issued (when the RAM reads).
  typedef struct {int cnt; int addr; logic [7:0] data;} ent_t;
  ent_t       pq[$];
  logic [7:0] shadow [16];
  logic       e_we, e_wack, e_rv, e_done, e_busy;
  logic [3:0] e_inaddr, e_outaddr, e_rdaddr;
  logic [1:0] e_din;
  logic [7:0] e_rddata;
  bit         scanning;
  int         next_a;
  logic       n_rv, n_done, n_busy, n_wack;
  logic [3:0] n_rdaddr;
  logic [7:0] n_rddata;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_we = 0; e_wack = 0; e_inaddr = 0; e_din = 0; e_outaddr = 0;
      e_rv = 0; e_rdaddr = 0; e_rddata = 0; e_done = 0; e_busy = 0;
      scanning = 0; next_a = 0;
      pq.delete();
    end else begin
      n_rv = 0; n_done = 0; n_busy = e_busy;
      n_rdaddr = e_rdaddr; n_rddata = e_rddata;
      if (pq.size() > 0 && pq[0].cnt == 0) begin
        n_rv = 1;
        n_rdaddr = 4'(pq[0].addr);
        n_rddata = pq[0].data;
        void'(pq.pop_front());
      end
      foreach (pq[i]) if (pq[i].cnt == 1) begin
        pq[i].data = shadow[pq[i].addr];
        pq[i].cnt  = 0;
      end
      if (preload) for (int i = 0; i < 16; i++) shadow[i] = 8'(8'h10 + i);
      else if (e_we) shadow[e_inaddr][1:0] = e_din;
      if (scanning && !e_we) begin
        pq.push_back('{cnt: 1, addr: next_a, data: 8'h00});
        if (next_a == 15) begin scanning = 0; next_a = 0; end
        else next_a++;
      end
      if (e_rv && e_rdaddr == 4'd15) begin n_done = 1; n_busy = 0; end
      if (!e_busy && start) begin n_busy = 1; scanning = 1; next_a = 0; end
      n_wack = wr_req && !e_wack;
      if (n_wack) begin e_inaddr = wr_addr; e_din = wr_data; end
      e_we = n_wack; e_wack = n_wack;
      e_rv = n_rv; e_rdaddr = n_rdaddr; e_rddata = n_rddata;
      e_done = n_done; e_busy = n_busy;
      e_outaddr = scanning ? 4'(next_a) : 4'd0;
    end
  end

  // ---------------- compare process ----------------
  int         sw_cnt = 0;
  int         sw_done = 0;
  logic [7:0] sw_data [16];
  always @(negedge clk) begin
    if (clrn) begin
      chk("ram_we", ram_we, e_we);
      chk("wr_ack", wr_ack, e_wack);
      chk("ram_inaddr", ram_inaddr, e_inaddr);
      chk("ram_din", ram_din, e_din);
      chk("ram_outaddr", ram_outaddr, e_outaddr);
      chk("rd_valid", rd_valid, e_rv);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (e_rv) begin
        chk("rd_addr", rd_addr, e_rdaddr);
        chk("rd_data", rd_data, e_rddata);
      end
      if (rd_valid) begin
        if (sw_cnt < 16) sw_data[sw_cnt] = rd_data;
        sw_cnt++;
      end
      if (done) sw_done++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_preload();
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
  endtask

  // Cycle k = k-th cycle after the edge that samples start.  wcyc=-1 puts the
  // write request in the start cycle itself; poke re-pulses start in SCAN/DRAIN.
  task automatic sweep(input int wcyc, input logic [3:0] wa, input logic [1:0] wd,
                       input bit poke, output int n);
    n = -1;
    sw_cnt = 0;
    sw_done = 0;
    @(posedge clk); #1;
    start = 1'b1;
    if (wcyc == -1) begin wr_req = 1'b1; wr_addr = wa; wr_data = wd; end
    for (int k = 0; k < 60 && n < 0; k++) begin
      @(posedge clk); #1;
      start = poke && (k == 8 || k == 17);
      if (wr_ack) wr_req = 1'b0;
      if (k == wcyc) begin wr_req = 1'b1; wr_addr = wa; wr_data = wd; end
      if (done) n = k;
    end
    start = 1'b0;
    wr_req = 1'b0;
    if (n < 0) chk("done_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  int         n, t;
  logic [5:0] we_pat, ack_pat;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #2 chk("reset_outputs", {wr_ack, ram_we, ram_inaddr, ram_din, ram_outaddr,
                             rd_valid, rd_addr, rd_data, busy, done}, 0);
    @(posedge clk); #3 clrn = 1'b1;
    do_preload();
    repeat (3) @(posedge clk);

    // plain sweep
    sweep(-2, 4'd0, 2'd0, 1'b0, n);
    chk("sweep_cycles", n, 19);
    chk("sweep_words", sw_cnt, 16);
    chk("sweep_done_pulses", sw_done, 1);
    for (int i = 0; i < 16; i++) chk("sweep_data", sw_data[i], 8'(8'h10 + i));
    chk("busy_after", busy, 0);

    // write at outaddr 5 during SCAN, ahead of the sweep
    sweep(4, 4'd12, 2'b11, 1'b0, n);
    chk("wr_scan_cycles", n, 20);
    chk("wr_scan_words", sw_cnt, 16);
    chk("wr_scan_word5", sw_data[5], 8'h15);
    chk("wr_scan_word12", sw_data[12], 8'h1F);

    // held write request in IDLE
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 4'd3; wr_data = 2'b10;
    we_pat = '0; ack_pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      we_pat  = {we_pat[4:0], ram_we};
      ack_pat = {ack_pat[4:0], wr_ack};
    end
    wr_req = 1'b0;
    chk("idle_we_pattern", we_pat, 6'b101010);
    chk("idle_ack_pattern", ack_pat, 6'b101010);
    repeat (3) @(posedge clk);

    // start pokes in SCAN and DRAIN are ignored
    do_preload();
    sweep(-2, 4'd0, 2'd0, 1'b1, n);
    chk("poke_cycles", n, 19);
    chk("poke_words", sw_cnt, 16);
    chk("poke_done_pulses", sw_done, 1);

    // reset while word 7 is in flight
    sw_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (e_outaddr != 4'd8 && t < 40) begin @(posedge clk); #1; t++; end
    if (t >= 40) chk("rst_wait_timeout", 0, 1);
    #2 clrn = 1'b0;
    #1 chk("rst_mid_outputs", {wr_ack, ram_we, ram_inaddr, ram_din, ram_outaddr,
                               rd_valid, rd_addr, rd_data, busy, done}, 0);
    repeat (2) @(posedge clk);
    #3 clrn = 1'b1;
    repeat (25) @(posedge clk);
    #1 chk("rst_no_done", sw_done, 0);
    sweep(-2, 4'd0, 2'd0, 1'b0, n);
    chk("rst_resweep_cycles", n, 19);
    chk("rst_resweep_words", sw_cnt, 16);
    chk("rst_resweep_word7", sw_data[7], 8'h17);

    // write in the start-sampling cycle
    do_preload();
    sweep(-1, 4'd0, 2'b01, 1'b0, n);
    chk("wr_start_cycles", n, 20);
    chk("wr_start_words", sw_cnt, 16);
    chk("wr_start_word0", sw_data[0], 8'h11);

    // random traffic against the model
    do_preload();
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      if (wr_ack) wr_req = 1'b0;
      else if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req  = 1'b1;
        wr_addr = 4'($urandom);
        wr_data = 2'($urandom);
      end
      start = ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    wr_req = 1'b0;
    repeat (30) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/ram_scan_ctrl.md
Name: ram_scan_ctrl

Overview:
- Initiator-side controller for the 16x8 dual-address lab RAM: owns its we/inaddr/din write port and its outaddr/dout read port.
- On start, sweeps every RAM address in order and returns each 8-bit word with its address tag.
- Interleaves 2-bit writes from a switch/key front-end, with writes taking priority over reads.
- Sits between board I/O (keys, switches, 7-seg scanner) and the RAM; it is the RAM's only driver.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word width.
- WDATA_W, 2, write data width; the RAM writes only bits [WDATA_W-1:0].
- LAST_ADDR, 15, final address of a sweep.

Ports:
- clk  input  1  system clock; all logic on posedge.
- clrn  input  1  asynchronous active-low reset.
- start  input  1  begins a sweep; sampled only in IDLE.
- wr_req  input  1  write request; held until wr_ack is seen.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WDATA_W  write data.
- wr_ack  output  1  one-cycle pulse; the write has been issued.
- ram_we  output  1  RAM write enable (registered).
- ram_inaddr  output  ADDR_W  RAM write address (registered).
- ram_din  output  WDATA_W  RAM write data (registered).
- ram_outaddr  output  ADDR_W  RAM read address (registered).
- ram_dout  input  DATA_W  RAM read data.
- rd_valid  output  1  one-cycle pulse; rd_addr/rd_data are valid.
- rd_addr  output  ADDR_W  address tag of the returned word.
- rd_data  output  DATA_W  returned word.
- busy  output  1  high in SCAN and DRAIN.
- done  output  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset (clrn=0, async):
  - All outputs go to 0; state goes to IDLE.
  - Tag pipeline and capture counter are cleared.
  - Reset mid-sweep aborts the sweep; no done pulse and no further rd_valid.
- RAM read timing, fixed:
  - Address presented in cycle C with ram_we=0 is latched internally at the end of C.
  - It appears on ram_dout after the following edge.
  - If ram_we=1 in cycle C, the RAM does not latch; that read slot is lost.
- Write path (every state, including IDLE):
  - Each edge: if wr_req=1 and wr_ack=0, then ram_we<=1, ram_inaddr<=wr_addr, ram_din<=wr_data, wr_ack<=1.
  - Otherwise ram_we<=0 and wr_ack<=0.
  - A held wr_req therefore produces at most one write per two cycles.
  - The requester drops wr_req after seeing wr_ack.
- States:
  - IDLE: ram_outaddr=0. start=1 moves to SCAN. start is ignored in every other state.
  - SCAN: a read is issued in each cycle where ram_we=0. At that edge, ram_outaddr increments.
    - If ram_outaddr==LAST_ADDR at an issuing edge, move to DRAIN instead; ram_outaddr wraps to 0.
    - A cycle with ram_we=1 issues nothing; ram_outaddr holds.
  - DRAIN: wait until both tag stages are empty and the last capture is done. Then pulse done and go to IDLE.
- Tag pipeline, two stages:
  - s1 <= {issue, ram_outaddr}; s2 <= s1.
  - When s2 is valid at an edge: rd_data<=ram_dout, rd_addr<=s2.addr, rd_valid<=1. Otherwise rd_valid<=0.
  - Latency: address issued in cycle C gives rd_valid in cycle C+3.
  - Steady state (no writes): rd_valid every cycle.
- Completion:
  - done asserts in the cycle after the rd_valid for LAST_ADDR.
  - busy falls in that same cycle.
  - A full sweep with no writes takes 16 issue cycles, and done is at cycle 19 after start is sampled.
- A write to an address already swept has no effect on the returned values. A write ahead of the sweep is reflected only in bits [1:0].
- rd_addr values are strictly increasing 0..LAST_ADDR within a sweep, with no duplicates or gaps.

Test Plan:
- Reset held, then released with RAM preloaded ram[i]=8'h10+i; start pulse -> rd_valid in 16 consecutive cycles, rd_addr 0..15, rd_data 8'h10..8'h1F, done one cycle after the last word, busy low afterward.
- During SCAN at ram_outaddr=5, wr_req with addr=12 and data=2'b11 -> one-cycle ram_we and wr_ack; no issue that cycle; rd_addr sequence has no gap; word 12 returns 8'h1F.
- wr_req held high for 6 cycles in IDLE -> ram_we pulses on cycles 1, 3, 5; wr_ack mirrors them; ram_outaddr stays 0; no rd_valid.
- start pulsed during SCAN and DRAIN -> ignored; exactly 16 rd_valid and one done.
- clrn dropped while rd_addr=7 is in flight -> all outputs 0 immediately; no done; a new start returns the full 0..15 sweep.
- Write addr=0, data=2'b01 issued in the same cycle start is sampled -> first read issues one cycle later; word 0 returns 8'h11.
